// File: rtl/alu_pkg.sv
// Shared op codes and sequencer state for the execute-stage ALU and its decoder.
// The iterative mult/div unit is built only when ALU_SEQ_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, one step
// per cycle; used by alu_seq only when ALU_SEQ_MULDIV_EN is defined.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output alu_state_t       state
);

  alu_state_t         state_nxt;
  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mag_b;
  logic               div_op, neg_q, neg_r, b_zero;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, shifted, trial;
  logic [WIDTH-1:0]   step_hi, step_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign mag_a_in = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b_in = (is_signed && b[WIDTH-1]) ? -b : b;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (cnt == (SHW+1)'(1)) begin
          state_nxt = ST_DONE;
          done      = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // acc_hi:acc_lo holds partial product (mult) or remainder:quotient (div).
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, mag_b};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (div_op) begin
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  // Divide by zero leaves |A| in the remainder, so only the quotient needs overriding.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = b_zero ? '1 : (neg_q ? -step_lo : step_lo);
    r_fix    = neg_r ? -step_hi : step_hi;
    res_hi   = div_op ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = div_op ? q_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_b  <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        cnt    <= (SHW+1)'(WIDTH);
        acc_hi <= '0;
        acc_lo <= mag_a_in;
        mag_b  <= mag_b_in;
        div_op <= is_div;
        neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= is_signed && is_div && a[WIDTH-1];
        b_zero <= is_div && (b == '0);
      end else if (state == ST_BUSY) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with HI/LO registers; ALU_SEQ_MULDIV_EN adds the
// iterative mult/div unit. Handshake: an op is taken when in_valid && in_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       Op,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic             Over,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept, single_op, ov;
  logic [SHW-1:0]   sa;
  logic [WIDTH-1:0] sum, diff, res;

  assign accept = in_valid && in_ready;
  assign sa     = A[SHW-1:0];
  assign sum    = A + B;
  assign diff   = A - B;

  always_comb begin
    res = '0;
    ov  = 1'b0;
    case (Op)
      OP_ADD: begin
        res = sum;
        ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: res = sum;
      OP_SUB: begin
        res = diff;
        ov  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: res = diff;
      OP_SLL:  res = B << sa;
      OP_SRL:  res = B >> sa;
      OP_SRA:  res = WIDTH'($signed(B) >>> sa);
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOR:  res = ~(A | B);
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  alu_state_t       md_state;

  assign single_op = accept && !is_muldiv(Op);
  assign in_ready  = (md_state == ST_IDLE);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_muldiv(Op)),
    .is_div    (Op[1]),
    .is_signed (!Op[0]),
    .a         (A),
    .b         (B),
    .done      (md_done),
    .res_hi    (md_hi),
    .res_lo    (md_lo),
    .state     (md_state)
  );
`else
  assign single_op = accept;
  assign in_ready  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      C         <= '0;
      Over      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= single_op;
      if (single_op) begin
        C    <= res;
        Over <= ov;
        if (Op == OP_MTHI) hi <= A;
        if (Op == OP_MTLO) lo <= A;
      end
`ifdef ALU_SEQ_MULDIV_EN
      // in_ready is low while the unit runs, so this never coincides with single_op.
      if (md_done) begin
        out_valid <= 1'b1;
        C         <= '0;
        Over      <= 1'b0;
        hi        <= md_hi;
        lo        <= md_lo;
      end
`endif
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the combinational integer ALU in the execute stage. Parametrised datapath width, plus an iterative multiply/divide unit writing HI/LO registers. Single-cycle ops complete with fixed one-cycle latency at full throughput. Multiply/divide stalls the issuing stage through `in_ready` for WIDTH+1 cycles.

## Interface
Parameters:
- `WIDTH`, 32 — operand/result width; a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH) — shift-amount width; derived, never overridden.

Ports:
- `clk`  in  1  — rising-edge clock.
- `reset`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — operation presented.
- `in_ready`  out  1  — unit can accept; accept = `in_valid && in_ready`.
- `A`  in  WIDTH  — operand A; shift amount is `A[SHW-1:0]`.
- `B`  in  WIDTH  — operand B; shift source.
- `Op`  in  6  — function code.
- `out_valid`  out  1  — one-cycle pulse: `C`/`Over` valid, or HI/LO update complete.
- `C`  out  WIDTH  — result.
- `Over`  out  1  — signed add/sub overflow.
- `hi`  out  WIDTH  — HI register.
- `lo`  out  WIDTH  — LO register.

## Operation
Op codes, all arithmetic modulo 2^WIDTH:
- 0x20 add: `Over` = operand signs equal and result sign differs.
- 0x21 addu: `Over` = 0.
- 0x22 sub: `Over` = operand signs differ and result sign ≠ A sign.
- 0x23 subu: `Over` = 0.
- 0x00 sll `B<<sa`, 0x02 srl `B>>sa`, 0x03 sra arithmetic `B>>>sa`.
- 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
- 0x10 mfhi: `C` = hi. 0x12 mflo: `C` = lo.
- 0x11 mthi: hi ← A. 0x13 mtlo: lo ← A.
- 0x18 mult / 0x19 multu: {hi,lo} ← A×B, 2·WIDTH-bit product.
- 0x1A div / 0x1B divu: lo ← quotient, hi ← remainder.
- Any other Op: accepted; `C` = 0, `Over` = 0, `out_valid` pulses.

Rules:
- `Over` is an indication only; `C` is always written.
- mthi/mtlo/mult/div drive `C` = 0 and `Over` = 0.
- Signed mult/div operate on magnitudes, then correct sign: quotient sign = A^B, remainder sign = A. Division truncates toward zero.
- div by zero (either signedness): lo = all ones, hi = A.
- div of most-negative by −1: lo = most-negative, hi = 0.

State machine: IDLE, BUSY, DONE.
- IDLE: `in_ready` = 1. On accepting mult/div, latch operands, load counter with WIDTH, go to BUSY. Other ops stay in IDLE.
- BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; counter decrements; at 0 go to DONE.
- DONE: sign-correct, write hi/lo, pulse `out_valid`, go to IDLE.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `C` = 0, `Over` = 0, `hi` = 0, `lo` = 0; state = IDLE.
- Single-cycle ops: accept in cycle N → `C`/`Over`/`out_valid` registered at N+1. Back-to-back accepts every cycle.
- mfhi/mflo read the value of hi/lo in the accept cycle. A preceding mthi/mtlo accepted in cycle N is visible to an mfhi/mflo accepted at N+1.
- mult/div: accepted at N; `in_ready` = 0 from N+1 through N+WIDTH+1; hi/lo and the `out_valid` pulse appear at N+WIDTH+1; `in_ready` = 1 again at N+WIDTH+2.
- `out_valid` has no backpressure. `C` and `Over` hold their last value until the next completing op.
- Inputs are ignored whenever `in_ready` = 0.
- `reset` asserted mid-BUSY aborts the operation: no `out_valid`, hi/lo cleared.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: mult/multu/div/divu implemented as above.
- Not defined: no iterative unit and no BUSY/DONE states; ops 0x18–0x1B behave as unknown ops (one-cycle, `C` = 0, hi/lo unchanged); `in_ready` is tied to 1.
- mfhi/mflo/mthi/mtlo are always present.

## Structure
- Shared package `alu_pkg`: Op code constants (`OP_ADD` … `OP_DIVU`, `OP_MFHI` …) and the state enum `alu_state_t`. Both are shared with the decoder.
- Sub-module `alu_muldiv_iter`: iterative multiplier/divider with start/done handshake and WIDTH-cycle counter; instantiated only under `ALU_SEQ_MULDIV_EN`.

## Test plan
- add 0x7FFFFFFF + 1 → `C` = 0x80000000, `Over` = 1, one cycle later; addu same operands → `Over` = 0.
- sra A = 4, B = 0xF0000000 → `C` = 0xFF000000; srl with same operands → `C` = 0x0F000000; back-to-back, one result per cycle.
- mult A = −3, B = 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, `out_valid` exactly 33 cycles after accept. mflo issued next → `C` = 0xFFFFFFF1.
- div A = −7, B = 2 → lo = −3, hi = −1. divu A = 7, B = 0 → lo = 0xFFFFFFFF, hi = 7.
- `reset` asserted 10 cycles into a divu → no `out_valid`, hi = lo = 0, `in_ready` = 1 immediately.
- Build without the macro: mult → `C` = 0 after 1 cycle, hi/lo unchanged; WIDTH = 16 run of the add/shift cases scaled to 16 bits.
